// File: rtl/clocked_dac_pkg.sv
// Shared types and helpers for clocked_dac.
//   state_t    : FSM encoding (IDLE, SETTLE)
//   SatW       : width carried into sat_q; the code->target intermediate must fit in it
//   GUARD_BITS : headroom added to OUT_WIDTH+CODE_WIDTH for the product/sum
//   sat_q      : clamp a wide signed value into the signed range of out_w bits
package clocked_dac_pkg;

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam int unsigned SatW       = 64;
  localparam int unsigned GUARD_BITS = 2;

  function automatic logic signed [SatW-1:0] sat_q(input logic signed [SatW-1:0] value,
                                                   input int unsigned            out_w);
    logic signed [SatW-1:0] max_v;
    logic signed [SatW-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/clocked_dac.sv
// Fixed-point emulation model of a clocked DAC. A code accepted through a valid/ready
// handshake is converted to target = sat(OFFSET_Q + code*LSB_Q) and driven onto out_q
// SETTLE_CYCLES edges after acceptance. A 1-deep hold register lets one further code be
// queued while a settle is running. Analog value = out_q * 2^OUT_EXP.
// Optional feature: define CLOCKED_DAC_SLEW_EN to slew-limit out_q by SLEW_Q per cycle;
// the counter then only sets a minimum settle time.
// Ports:
//   clk        in   emulation clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   code       in   requested DAC code (unsigned)
//   code_valid in   code is valid this cycle
//   code_ready out  a code can be accepted this cycle
//   out_q      out  signed fixed-point analog output
//   settled    out  out_q equals target of the most recent accepted code
//   busy       out  settle in progress
module clocked_dac
  import clocked_dac_pkg::*;
#(
  parameter int unsigned CODE_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH     = 16,
  parameter int          OUT_EXP       = -8,
  parameter int          LSB_Q         = 10,
  parameter int          OFFSET_Q      = 0,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int          SLEW_Q        = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CODE_WIDTH-1:0]       code,
  input  logic                        code_valid,
  output logic                        code_ready,
  output logic signed [OUT_WIDTH-1:0] out_q,
  output logic                        settled,
  output logic                        busy
);

  localparam int unsigned WideW  = OUT_WIDTH + CODE_WIDTH + GUARD_BITS;
  localparam int unsigned CntW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(SETTLE_CYCLES - 1);
  localparam logic signed [OUT_WIDTH-1:0] RstOut =
      OUT_WIDTH'(sat_q(SatW'(OFFSET_Q), OUT_WIDTH));

  state_t                      state_q;
  logic [CntW-1:0]             cnt_q;
  logic signed [OUT_WIDTH-1:0] target_q;
  logic signed [OUT_WIDTH-1:0] hold_q;
  logic                        hold_full_q;
  logic                        ready_en_q;  // keeps code_ready low until one edge after reset

  logic signed [WideW-1:0]     code_w;
  logic signed [WideW-1:0]     prod_w;
  logic signed [WideW-1:0]     sum_w;
  logic signed [OUT_WIDTH-1:0] new_target;
  logic                        xfer;
  logic                        done;

  // OUT_EXP only documents the fixed-point scaling; SLEW_Q is idle in the step build.
  logic unused_params;
  assign unused_params = (^SLEW_Q) ^ (^OUT_EXP);

  // Code is unsigned: zero-extend before entering the signed domain.
  assign code_w     = $signed(WideW'(code));
  assign prod_w     = code_w * $signed(WideW'(LSB_Q));
  assign sum_w      = prod_w + $signed(WideW'(OFFSET_Q));
  assign new_target = OUT_WIDTH'(sat_q(SatW'(sum_w), OUT_WIDTH));

  assign code_ready = ready_en_q && ((state_q == IDLE) || !hold_full_q);
  assign xfer       = code_valid && code_ready;

`ifdef CLOCKED_DAC_SLEW_EN
  localparam logic signed [OUT_WIDTH:0] SlewStep = (OUT_WIDTH + 1)'(SLEW_Q);

  logic signed [OUT_WIDTH:0]   diff;
  logic signed [OUT_WIDTH-1:0] slew_out;

  // Final step lands exactly on target so out_q never overshoots.
  always_comb begin
    diff = $signed({target_q[OUT_WIDTH-1], target_q}) - $signed({out_q[OUT_WIDTH-1], out_q});
    if (diff > SlewStep) begin
      slew_out = out_q + OUT_WIDTH'(SLEW_Q);
    end else if (diff < -SlewStep) begin
      slew_out = out_q - OUT_WIDTH'(SLEW_Q);
    end else begin
      slew_out = target_q;
    end
  end

  assign done = (cnt_q == '0) && (slew_out == target_q);
`else
  assign done = (cnt_q == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      target_q    <= RstOut;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_en_q  <= 1'b0;
      out_q       <= RstOut;
      settled     <= 1'b1;
      busy        <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            target_q <= new_target;
            cnt_q    <= Reload;
            busy     <= 1'b1;
            settled  <= 1'b0;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
`ifdef CLOCKED_DAC_SLEW_EN
          out_q <= slew_out;
`endif
          if (done) begin
`ifndef CLOCKED_DAC_SLEW_EN
            out_q <= target_q;
`endif
            if (hold_full_q) begin
              target_q    <= hold_q;
              hold_full_q <= 1'b0;
              cnt_q       <= Reload;
            end else if (xfer) begin
              // Code arriving on the completion edge skips the hold register.
              target_q <= new_target;
              cnt_q    <= Reload;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
              settled <= 1'b1;
            end
          end else begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CntW'(1);
            end
            if (xfer) begin
              hold_q      <= new_target;
              hold_full_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clocked_dac.sv
// Directed bench for clocked_dac (step build). Three instances share stimulus: default
// parameters, a high-offset variant that saturates positive, and a negative-LSB variant
// pinned at the negative rail.
module tb_clocked_dac;

  logic              clk;
  logic              rst_n;
  logic [7:0]        code;
  logic              code_valid;

  logic              ready_d, settled_d, busy_d;
  logic signed [15:0] out_d;
  logic              ready_h, settled_h, busy_h;
  logic signed [15:0] out_h;
  logic              ready_l, settled_l, busy_l;
  logic signed [15:0] out_l;

  int checks = 0;
  int errors = 0;

  clocked_dac u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (ready_d),
    .out_q      (out_d),
    .settled    (settled_d),
    .busy       (busy_d)
  );

  clocked_dac #(.OFFSET_Q(32000)) u_hi (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (ready_h),
    .out_q      (out_h),
    .settled    (settled_h),
    .busy       (busy_h)
  );

  clocked_dac #(.OFFSET_Q(-32768), .LSB_Q(-1)) u_lo (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (ready_l),
    .out_q      (out_l),
    .settled    (settled_l),
    .busy       (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b1;
    code       = '0;
    code_valid = 1'b0;

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out", out_d, 0);
    chk("rst_settled", {31'b0, settled_d}, 1);
    chk("rst_busy", {31'b0, busy_d}, 0);
    chk("rst_ready", {31'b0, ready_d}, 0);
    chk("rst_out_hi", out_h, 32000);
    chk("rst_out_lo", out_l, -32768);
    tick();
    tick();
    chk("rst_ready_held", {31'b0, ready_d}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", {31'b0, ready_d}, 0);
    tick();
    chk("rel_ready_after_edge", {31'b0, ready_d}, 1);

    // Single code 255 -> 2550 three edges after acceptance
    code = 8'd255;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("c255_busy_k", {31'b0, busy_d}, 1);
    chk("c255_settled_k", {31'b0, settled_d}, 0);
    chk("c255_ready_k", {31'b0, ready_d}, 1);
    chk("c255_out_k", out_d, 0);
    tick();
    chk("c255_out_k1", out_d, 0);
    tick();
    chk("c255_out_k2", out_d, 0);
    chk("c255_busy_k2", {31'b0, busy_d}, 1);
    tick();
    chk("c255_out_k3", out_d, 2550);
    chk("c255_settled_k3", {31'b0, settled_d}, 1);
    chk("c255_busy_k3", {31'b0, busy_d}, 0);
    chk("c255_out_hi", out_h, 32767);
    chk("c255_out_lo", out_l, -32768);

    // Back-to-back 10, 20, 30 with valid held high
    code = 8'd10;
    code_valid = 1'b1;
    tick();
    chk("b2b_ready_after10", {31'b0, ready_d}, 1);
    code = 8'd20;
    tick();
    chk("b2b_ready_after20", {31'b0, ready_d}, 0);
    code = 8'd30;
    tick();
    chk("b2b_stall", {31'b0, ready_d}, 0);
    chk("b2b_out_hold", out_d, 2550);
    tick();
    chk("b2b_out100", out_d, 100);
    chk("b2b_settled_pending", {31'b0, settled_d}, 0);
    chk("b2b_ready_freed", {31'b0, ready_d}, 1);
    tick();
    code_valid = 1'b0;
    chk("b2b_ready_after30", {31'b0, ready_d}, 0);
    chk("b2b_out100_k4", out_d, 100);
    tick();
    chk("b2b_out100_k5", out_d, 100);
    tick();
    chk("b2b_out200", out_d, 200);
    chk("b2b_busy200", {31'b0, busy_d}, 1);
    tick();
    tick();
    chk("b2b_out200_k8", out_d, 200);
    tick();
    chk("b2b_out300", out_d, 300);
    chk("b2b_settled300", {31'b0, settled_d}, 1);
    chk("b2b_busy300", {31'b0, busy_d}, 0);
    chk("b2b_out_hi", out_h, 32300);

    // Code presented on the completion edge becomes the target directly
    code = 8'd5;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    tick();
    code = 8'd9;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("edge_out50", out_d, 50);
    chk("edge_busy", {31'b0, busy_d}, 1);
    chk("edge_settled", {31'b0, settled_d}, 0);
    chk("edge_ready", {31'b0, ready_d}, 1);
    chk("edge_out_hi", out_h, 32050);
    chk("edge_out_lo", out_l, -32768);
    tick();
    tick();
    chk("edge_out50_k2", out_d, 50);
    tick();
    chk("edge_out90", out_d, 90);
    chk("edge_settled90", {31'b0, settled_d}, 1);

    // Same code again still runs a full settle
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("same_settled_drop", {31'b0, settled_d}, 0);
    chk("same_out_hold", out_d, 90);
    tick();
    tick();
    chk("same_busy_k2", {31'b0, busy_d}, 1);
    tick();
    chk("same_settled_back", {31'b0, settled_d}, 1);
    chk("same_out90", out_d, 90);

    // Reset mid-settle discards the pending code
    code = 8'd100;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out_d, 0);
    chk("mid_rst_busy", {31'b0, busy_d}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_rel_out", out_d, 0);
    chk("mid_rel_settled", {31'b0, settled_d}, 1);
    chk("mid_rel_busy", {31'b0, busy_d}, 0);
    chk("mid_rel_ready", {31'b0, ready_d}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
